ren_conv_seq: RTL and testbench

REN_CONV_SEQ -- requirements
Module: ren_conv_seq

---
 rtl/ren_conv_seq.sv | 164 ++++++++++++++++
 tb/tb_ren_conv_seq.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ren_conv_seq.sv
// ren_conv_seq: descriptor-queue sequencer driving a convolver through start/done/soft-reset.
// Define REN_CONV_SEQ_TIMEOUT_EN to add the RUN watchdog and the sticky err_timeout output.
module ren_conv_seq #(
  parameter int unsigned QDEPTH_LOG2   = 2,
  parameter int unsigned TIMEOUT_WIDTH = 16
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 desc_valid,
  output logic                 desc_ready,
  input  logic [35:0]          desc_data,
  input  logic                 abort,
  input  logic                 conv_done,
  output logic                 conv_start,
  output logic                 conv_soft_reset,
  output logic [2:0]           cfg_kern_cols,
  output logic [7:0]           cfg_cols,
  output logic [2:0]           cfg_kerns,
  output logic [5:0]           cfg_stride,
  output logic [5:0]           cfg_result_cols,
  output logic [3:0]           cfg_shift,
  output logic                 cfg_en_max_pool,
  output logic [2:0]           cfg_mask,
  output logic                 cfg_kern_addr_mode,
  output logic                 busy,
  output logic                 irq,
  output logic [7:0]           jobs_done,
`ifdef REN_CONV_SEQ_TIMEOUT_EN
  output logic                 err_timeout,
`endif
  output logic [QDEPTH_LOG2:0] q_level
);

  localparam int unsigned DEPTH = 1 << QDEPTH_LOG2;
  localparam logic [QDEPTH_LOG2:0] PTR_ONE = {{QDEPTH_LOG2{1'b0}}, 1'b1};

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_FLUSH = 3'd4;

  logic [2:0]             r_state;
  logic                   r_flush_cnt;
  logic [QDEPTH_LOG2:0]   r_wptr;
  logic [QDEPTH_LOG2:0]   r_rptr;
  logic [35:0]            r_mem [DEPTH];
  logic [35:0]            r_job;
  logic                   r_done_q;
  logic [7:0]             r_jobs;

  logic [QDEPTH_LOG2:0]   w_level;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_done_rise;

`ifdef REN_CONV_SEQ_TIMEOUT_EN
  localparam logic [TIMEOUT_WIDTH-1:0] WD_LAST = {{(TIMEOUT_WIDTH-1){1'b1}}, 1'b0};
  localparam logic [TIMEOUT_WIDTH-1:0] WD_ONE  = {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};
  logic [TIMEOUT_WIDTH-1:0] r_wd;
  logic                     r_err;
  assign err_timeout = r_err;
`else
  if (TIMEOUT_WIDTH == 0) begin : g_no_watchdog
  end
`endif

  assign w_level     = r_wptr - r_rptr;
  assign w_full      = w_level[QDEPTH_LOG2];
  assign w_empty     = (w_level == '0);
  // Ready is withheld during abort and flush so a colliding push is simply dropped.
  assign desc_ready  = ~w_full & ~abort & (r_state != S_FLUSH);
  assign w_push      = desc_valid & desc_ready;
  assign w_done_rise = conv_done & ~r_done_q;

  assign conv_start      = (r_state == S_LOAD);
  assign conv_soft_reset = (r_state == S_FLUSH);
  assign busy            = (r_state != S_IDLE);
  assign irq             = (r_state == S_DONE) & r_job[35];
  assign jobs_done       = r_jobs;
  assign q_level         = w_level;

  assign cfg_kern_cols      = r_job[2:0];
  assign cfg_cols           = r_job[10:3];
  assign cfg_kerns          = r_job[13:11];
  assign cfg_stride         = r_job[19:14];
  assign cfg_result_cols    = r_job[25:20];
  assign cfg_shift          = r_job[29:26];
  assign cfg_en_max_pool    = r_job[30];
  assign cfg_mask           = r_job[33:31];
  assign cfg_kern_addr_mode = r_job[34];

  always_ff @(posedge wb_clk_i) begin
    if (w_push) r_mem[r_wptr[QDEPTH_LOG2-1:0]] <= desc_data;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) r_done_q <= 1'b0;
    else          r_done_q <= conv_done;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state     <= S_IDLE;
      r_flush_cnt <= 1'b0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_job       <= '0;
      r_jobs      <= '0;
`ifdef REN_CONV_SEQ_TIMEOUT_EN
      r_wd        <= '0;
      r_err       <= 1'b0;
`endif
    end else if (abort) begin
      r_state     <= S_FLUSH;
      r_flush_cnt <= 1'b0;
      r_wptr      <= '0;
      r_rptr      <= '0;
`ifdef REN_CONV_SEQ_TIMEOUT_EN
      r_err       <= 1'b0;
`endif
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_job   <= r_mem[r_rptr[QDEPTH_LOG2-1:0]];
            r_rptr  <= r_rptr + PTR_ONE;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
`ifdef REN_CONV_SEQ_TIMEOUT_EN
          r_wd    <= '0;
`endif
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (w_done_rise) r_state <= S_DONE;
`ifdef REN_CONV_SEQ_TIMEOUT_EN
          else if (r_wd == WD_LAST) begin
            r_err       <= 1'b1;
            r_flush_cnt <= 1'b0;
            r_state     <= S_FLUSH;
          end else r_wd <= r_wd + WD_ONE;
`endif
        end
        S_DONE: begin
          r_jobs  <= r_jobs + 8'd1;
          r_state <= S_IDLE;
        end
        S_FLUSH: begin
          if (r_flush_cnt) begin
            r_flush_cnt <= 1'b0;
            r_state     <= S_IDLE;
          end else r_flush_cnt <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ren_conv_seq.sv
// Scoreboard bench for ren_conv_seq: expected descriptors are queued on push and checked at conv_start.
module tb_ren_conv_seq;

`ifdef REN_CONV_SEQ_TIMEOUT_EN
  localparam int TW = 4;
`else
  localparam int TW = 16;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        desc_valid, desc_ready, abort, conv_done;
  logic [35:0] desc_data;
  logic        conv_start, conv_soft_reset, busy, irq;
  logic [2:0]  cfg_kern_cols, cfg_kerns, cfg_mask;
  logic [7:0]  cfg_cols, jobs_done;
  logic [5:0]  cfg_stride, cfg_result_cols;
  logic [3:0]  cfg_shift;
  logic        cfg_en_max_pool, cfg_kern_addr_mode;
  logic [2:0]  q_level;
`ifdef REN_CONV_SEQ_TIMEOUT_EN
  logic        err_timeout;
`endif
  logic [34:0] cfg_obs;

  int n_checks = 0;
  int n_errors = 0;
  int irq_seen = 0;
  int exp_irq  = 0;
  int exp_jobs = 0;
  logic        cur_irq = 1'b0;
  logic        prev_start = 1'b0;
  logic [35:0] exp_q[$];

  always #5 clk = ~clk;

  assign cfg_obs = {cfg_kern_addr_mode, cfg_mask, cfg_en_max_pool, cfg_shift,
                    cfg_result_cols, cfg_stride, cfg_kerns, cfg_cols, cfg_kern_cols};

  ren_conv_seq #(.QDEPTH_LOG2(2), .TIMEOUT_WIDTH(TW)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_data(desc_data),
    .abort(abort), .conv_done(conv_done),
    .conv_start(conv_start), .conv_soft_reset(conv_soft_reset),
    .cfg_kern_cols(cfg_kern_cols), .cfg_cols(cfg_cols), .cfg_kerns(cfg_kerns),
    .cfg_stride(cfg_stride), .cfg_result_cols(cfg_result_cols), .cfg_shift(cfg_shift),
    .cfg_en_max_pool(cfg_en_max_pool), .cfg_mask(cfg_mask),
    .cfg_kern_addr_mode(cfg_kern_addr_mode),
    .busy(busy), .irq(irq), .jobs_done(jobs_done),
`ifdef REN_CONV_SEQ_TIMEOUT_EN
    .err_timeout(err_timeout),
`endif
    .q_level(q_level)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [35:0] rand_desc(input logic irq_bit);
    logic [63:0] r;
    logic [35:0] d;
    r = {$urandom(), $urandom()};
    d = r[35:0];
    d[35] = irq_bit;
    return d;
  endfunction

  task automatic push(input logic [35:0] d);
    int n = 0;
    desc_data  = d;
    desc_valid = 1'b1;
    while (!desc_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready", desc_ready, 1);
    if (desc_ready) exp_q.push_back(d);
    @(negedge clk);
    desc_valid = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (!conv_start && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(tag, conv_start, 1);
  endtask

  // Must be entered in LOAD or RUN; leaves the DUT in DONE at return.
  task automatic finish_job();
    conv_done = 1'b0;
    @(negedge clk);
    conv_done = 1'b1;
    @(negedge clk);
    conv_done = 1'b0;
    exp_jobs++;
    if (cur_irq) exp_irq++;
  endtask

  always @(negedge clk) begin : mon
    logic [35:0] d;
    if (!rst) begin
      if (irq) irq_seen++;
      if (conv_start) begin
        chk("start_width", prev_start, 0);
        chk("start_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          d = exp_q.pop_front();
          chk("cfg_fields", cfg_obs, d[34:0]);
          cur_irq = d[35];
        end
      end
      prev_start = conv_start;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [35:0] d;
    int n;
    rst = 1'b1; desc_valid = 1'b0; desc_data = '0; abort = 1'b0; conv_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", desc_ready, 1);
    chk("rst_qlevel", q_level, 0);
    chk("rst_start", conv_start, 0);
    chk("rst_softrst", conv_soft_reset, 0);
    chk("rst_busy", busy, 0);
    chk("rst_irq", irq, 0);
    chk("rst_jobs", jobs_done, 0);
    chk("rst_cfg", cfg_obs, 0);
`ifdef REN_CONV_SEQ_TIMEOUT_EN
    chk("rst_err", err_timeout, 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // single job: start two edges after the push, irq pulse, counter bump
    d = '0; d[10:3] = 8'd8; d[19:14] = 6'd1; d[35] = 1'b1; d[2:0] = 3'd3; d[29:26] = 4'd5;
    desc_data = d; desc_valid = 1'b1; exp_q.push_back(d);
    @(negedge clk);
    desc_valid = 1'b0;
    chk("lat_start_early", conv_start, 0);
    chk("lat_qlevel", q_level, 1);
    @(negedge clk);
    chk("lat_start", conv_start, 1);
    chk("lat_cols", cfg_cols, 8);
    chk("lat_stride", cfg_stride, 1);
    chk("lat_busy", busy, 1);
    @(negedge clk);
    chk("lat_start_once", conv_start, 0);
    repeat (2) @(negedge clk);
    conv_done = 1'b1;
    @(negedge clk);
    chk("irq_pulse", irq, 1);
    chk("jobs_before", jobs_done, 0);
    conv_done = 1'b0;
    @(negedge clk);
    chk("irq_width", irq, 0);
    chk("jobs_one", jobs_done, 1);
    chk("idle_busy", busy, 0);
    chk("cfg_hold", cfg_cols, 8);
    exp_jobs = 1; exp_irq = 1;

    // stale conv_done level must not complete the next job
    conv_done = 1'b1;
    push(rand_desc(1'b0));
    wait_start("held_start");
    repeat (6) @(negedge clk);
    chk("held_busy", busy, 1);
    chk("held_jobs", jobs_done, exp_jobs);
    finish_job();
    @(negedge clk);
    chk("held_jobs_after", jobs_done, exp_jobs);

    // fill the queue behind a stalled job; the sixth push has to wait
    fork
      for (int i = 0; i < 6; i++) push(rand_desc(1'(i & 1)));
    join_none
    n = 0;
    while (q_level != 3'd4 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("full_level", q_level, 4);
    chk("full_ready", desc_ready, 0);
    finish_job();
    for (int j = 1; j < 6; j++) begin
      wait_start("stall_start");
      finish_job();
    end
    repeat (2) @(negedge clk);
    chk("stall_jobs", jobs_done, exp_jobs);
    chk("stall_drain", exp_q.size(), 0);
    chk("stall_qlevel", q_level, 0);

    // abort beats a simultaneous conv_done rise and a push
    push(rand_desc(1'b1));
    wait_start("abort_start");
    for (int i = 0; i < 3; i++) push(rand_desc(1'b1));
    chk("abort_pre_qlevel", q_level, 3);
    abort = 1'b1; conv_done = 1'b1; desc_valid = 1'b1; desc_data = rand_desc(1'b1);
    exp_q.delete();
    @(negedge clk);
    chk("abort_soft_held", conv_soft_reset, 1);
    chk("abort_ready", desc_ready, 0);
    chk("abort_qlevel", q_level, 0);
    @(negedge clk);
    abort = 1'b0; conv_done = 1'b0; desc_valid = 1'b0;
    chk("abort_soft1", conv_soft_reset, 1);
    @(negedge clk);
    chk("abort_soft2", conv_soft_reset, 1);
    @(negedge clk);
    chk("abort_soft_end", conv_soft_reset, 0);
    chk("abort_busy", busy, 0);
    chk("abort_jobs", jobs_done, exp_jobs);
    repeat (3) @(negedge clk);
    chk("abort_stays_idle", busy, 0);
    chk("abort_irq", irq_seen, exp_irq);

    // run the counter up to 255 and across the wrap
    n = 0;
    while (exp_jobs < 255 && n < 300) begin
      push(rand_desc(1'($urandom_range(0, 1))));
      wait_start("wrap_start");
      finish_job();
      n++;
    end
    @(negedge clk);
    chk("jobs_255", jobs_done, 255);
    push(rand_desc(1'b0));
    wait_start("wrap_last_start");
    finish_job();
    @(negedge clk);
    chk("jobs_wrap", jobs_done, exp_jobs % 256);

`ifdef REN_CONV_SEQ_TIMEOUT_EN
    push(rand_desc(1'b1));
    push(rand_desc(1'b0));
    wait_start("wd_start");
    n = 0;
    while (!conv_soft_reset && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("wd_cycles", n, 16);
    chk("wd_err", err_timeout, 1);
    chk("wd_jobs", jobs_done, exp_jobs % 256);
    @(negedge clk);
    chk("wd_soft2", conv_soft_reset, 1);
    wait_start("wd_next_start");
    finish_job();
    @(negedge clk);
    chk("wd_err_sticky", err_timeout, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("wd_err_clear", err_timeout, 0);
`endif

    repeat (3) @(negedge clk);
    chk("irq_total", irq_seen, exp_irq);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
